// File: rtl/rand_backoff_if.sv
`default_nettype none
// ============================================================================
// Module      : rand_backoff_if
// Description : Request/status bundle between a retry controller, the LFSR
//               and the rand_backoff timer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rand_backoff_if;
  logic        start_i;
  logic [4:0]  attempt_i;
  logic        abort_i;
  logic [15:0] rand_i;
  logic        next_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] slots_o;

  modport slave (
    input  start_i,
    input  attempt_i,
    input  abort_i,
    input  rand_i,
    output next_o,
    output busy_o,
    output done_o,
    output slots_o
  );

  modport master (
    output start_i,
    output attempt_i,
    output abort_i,
    output rand_i,
    input  next_o,
    input  busy_o,
    input  done_o,
    input  slots_o
  );
endinterface
`default_nettype wire

// File: rtl/rand_backoff.sv
`default_nettype none
// ============================================================================
// Module      : rand_backoff
// Description : Binary-exponential random backoff timer fed by an LFSR stream.
// Revision    : 1.0 - initial release
// ============================================================================
module rand_backoff #(
  parameter int MAX_EXP     = 10,
  parameter int SLOT_CYCLES = 1
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  rand_backoff_if.slave   bus
);

  localparam int              c_PRE_W      = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_RELOAD = c_PRE_W'(SLOT_CYCLES - 1);
  localparam logic [4:0]      c_MAX_EXP    = 5'(MAX_EXP);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           exp_q,   exp_d;
  logic [15:0]          slots_q, slots_d;
  logic [15:0]          cnt_q,   cnt_d;
  logic [c_PRE_W-1:0]   pre_q,   pre_d;

  logic [15:0]          w_mask;
  logic [15:0]          w_draw;

  // 17-bit arithmetic so that an exponent of 16 yields an all-ones mask
  assign w_mask = 16'((17'd1 << exp_q) - 17'd1);
  assign w_draw = bus.rand_i & w_mask;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    slots_d = slots_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.abort_i) begin
          exp_d   = (bus.attempt_i > c_MAX_EXP) ? c_MAX_EXP : bus.attempt_i;
          state_d = S_DRAW;
        end
      end

      S_DRAW: begin
        slots_d = w_draw;
        cnt_d   = w_draw;
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else if (w_draw == 16'd0) begin
          state_d = S_DONE;
        end else begin
          pre_d   = c_PRE_RELOAD;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else if (pre_q != '0) begin
          pre_d = pre_q - 1'b1;
        end else if (cnt_q <= 16'd1) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 16'd1;
          pre_d = c_PRE_RELOAD;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      exp_q   <= '0;
      slots_q <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      slots_q <= slots_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

  // Status strobes come straight from the state register
  assign bus.next_o  = (state_q == S_DRAW);
  assign bus.busy_o  = (state_q != S_IDLE);
  assign bus.done_o  = (state_q == S_DONE);
  assign bus.slots_o = slots_q;

endmodule
`default_nettype wire

// File: tb/tb_rand_backoff.sv
`default_nettype none
// ============================================================================
// Module      : tb_rand_backoff
// Description : Directed self-checking bench for rand_backoff.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rand_backoff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rand_backoff_if ifa ();
  rand_backoff_if ifb ();
  rand_backoff_if ifc ();

  rand_backoff #(.MAX_EXP(10), .SLOT_CYCLES(4)) u_a (.clk_i(clk), .rst_i(rst), .bus(ifa.slave));
  rand_backoff #(.MAX_EXP(10), .SLOT_CYCLES(1)) u_b (.clk_i(clk), .rst_i(rst), .bus(ifb.slave));
  rand_backoff #(.MAX_EXP(16), .SLOT_CYCLES(1)) u_c (.clk_i(clk), .rst_i(rst), .bus(ifc.slave));

  int checks   = 0;
  int failures = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic launch_a(input logic [4:0] att, input logic [15:0] r);
    ifa.attempt_i = att;
    ifa.rand_i    = r;
    ifa.start_i   = 1'b1;
    step();
    ifa.start_i   = 1'b0;
  endtask

  // Checks cycles t+1..t+n after a start accepted at edge t; leaves us in t+n+1
  task automatic watch_a(input string tag, input int n, input int done_at);
    for (int k = 1; k <= n; k++) begin
      chk($sformatf("%s_next_c%0d", tag, k), 32'(ifa.next_o), 32'(k == 1));
      chk($sformatf("%s_busy_c%0d", tag, k), 32'(ifa.busy_o), 32'(k <= done_at));
      chk($sformatf("%s_done_c%0d", tag, k), 32'(ifa.done_o), 32'(k == done_at));
      step();
    end
  endtask

  initial begin
    int done_cyc;
    int done_cnt;
    int next_cnt;

    ifa.start_i = 1'b0; ifa.attempt_i = '0; ifa.abort_i = 1'b0; ifa.rand_i = '0;
    ifb.start_i = 1'b0; ifb.attempt_i = '0; ifb.abort_i = 1'b0; ifb.rand_i = '0;
    ifc.start_i = 1'b0; ifc.attempt_i = '0; ifc.abort_i = 1'b0; ifc.rand_i = '0;

    // Reset state
    step();
    step();
    chk("rst_a_busy",  32'(ifa.busy_o),  32'd0);
    chk("rst_a_next",  32'(ifa.next_o),  32'd0);
    chk("rst_a_done",  32'(ifa.done_o),  32'd0);
    chk("rst_a_slots", 32'(ifa.slots_o), 32'd0);
    chk("rst_b_busy",  32'(ifb.busy_o),  32'd0);
    chk("rst_c_slots", 32'(ifc.slots_o), 32'd0);
    rst = 1'b0;
    step();

    // Basic draw: 0xACE1 & 7 = 1 slot of 4 cycles, done at t+6
    launch_a(5'd3, 16'hACE1);
    watch_a("basic", 7, 6);
    chk("basic_slots", 32'(ifa.slots_o), 32'd1);

    // Zero window: done at t+2
    launch_a(5'd0, 16'hFFFF);
    watch_a("zero", 3, 2);
    chk("zero_slots", 32'(ifa.slots_o), 32'd0);

    // Abort in WAIT at t+3, restart at t+4
    launch_a(5'd3, 16'hACE1);
    step();
    step();
    ifa.abort_i = 1'b1;
    chk("abort_busy_t3", 32'(ifa.busy_o), 32'd1);
    step();
    ifa.abort_i = 1'b0;
    chk("abort_busy_t4", 32'(ifa.busy_o), 32'd0);
    chk("abort_done_t4", 32'(ifa.done_o), 32'd0);
    launch_a(5'd2, 16'h0005);
    watch_a("restart", 7, 6);
    chk("restart_slots", 32'(ifa.slots_o), 32'd1);

    // Abort in DRAW still updates slots_o
    launch_a(5'd2, 16'h0003);
    ifa.abort_i = 1'b1;
    step();
    ifa.abort_i = 1'b0;
    chk("abort_draw_busy",  32'(ifa.busy_o),  32'd0);
    chk("abort_draw_slots", 32'(ifa.slots_o), 32'd3);
    chk("abort_draw_done",  32'(ifa.done_o),  32'd0);
    step();
    chk("abort_draw_done2", 32'(ifa.done_o),  32'd0);

    // Asynchronous reset mid-WAIT
    launch_a(5'd3, 16'hACE1);
    step();
    step();
    chk("pre_rst_busy",  32'(ifa.busy_o),  32'd1);
    chk("pre_rst_slots", 32'(ifa.slots_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",  32'(ifa.busy_o),  32'd0);
    chk("arst_slots", 32'(ifa.slots_o), 32'd0);
    chk("arst_done",  32'(ifa.done_o),  32'd0);
    chk("arst_next",  32'(ifa.next_o),  32'd0);
    #2 rst = 1'b0;
    step();
    chk("post_rst_busy", 32'(ifa.busy_o), 32'd0);
    chk("post_rst_done", 32'(ifa.done_o), 32'd0);
    chk("post_rst_next", 32'(ifa.next_o), 32'd0);
    launch_a(5'd3, 16'hACE1);
    watch_a("post_rst", 7, 6);
    chk("post_rst_slots", 32'(ifa.slots_o), 32'd1);

    // start_i held through a whole backoff: one draw, next one only after IDLE
    ifa.attempt_i = 5'd3;
    ifa.rand_i    = 16'hACE1;
    ifa.start_i   = 1'b1;
    step();
    watch_a("hold1", 6, 6);
    chk("hold_idle_busy", 32'(ifa.busy_o), 32'd0);
    chk("hold_idle_next", 32'(ifa.next_o), 32'd0);
    step();
    ifa.start_i = 1'b0;
    watch_a("hold2", 7, 6);

    // start_i with abort_i in IDLE starts nothing
    ifa.start_i = 1'b1;
    ifa.abort_i = 1'b1;
    step();
    chk("sa_busy1", 32'(ifa.busy_o), 32'd0);
    chk("sa_next1", 32'(ifa.next_o), 32'd0);
    step();
    chk("sa_busy2", 32'(ifa.busy_o), 32'd0);
    ifa.start_i = 1'b0;
    ifa.abort_i = 1'b0;

    // Clamp to MAX_EXP=10: 1023 slots, done at t+1025
    ifb.attempt_i = 5'd20;
    ifb.rand_i    = 16'hFFFF;
    ifb.start_i   = 1'b1;
    step();
    ifb.start_i   = 1'b0;
    done_cyc = 0; done_cnt = 0; next_cnt = 0;
    for (int k = 1; k <= 1030; k++) begin
      if (ifb.done_o) begin done_cnt++; done_cyc = k; end
      if (ifb.next_o) next_cnt++;
      step();
    end
    chk("clamp10_done_cycle", 32'(done_cyc),      32'd1025);
    chk("clamp10_done_count", 32'(done_cnt),      32'd1);
    chk("clamp10_next_count", 32'(next_cnt),      32'd1);
    chk("clamp10_slots",      32'(ifb.slots_o),   32'd1023);
    chk("clamp10_busy_end",   32'(ifb.busy_o),    32'd0);

    // MAX_EXP=16: full 16-bit window, done at t+65537
    ifc.attempt_i = 5'd20;
    ifc.rand_i    = 16'hFFFF;
    ifc.start_i   = 1'b1;
    step();
    ifc.start_i   = 1'b0;
    done_cyc = 0; done_cnt = 0; next_cnt = 0;
    for (int k = 1; k <= 65540; k++) begin
      if (ifc.done_o) begin done_cnt++; done_cyc = k; end
      if (ifc.next_o) next_cnt++;
      step();
    end
    chk("clamp16_done_cycle", 32'(done_cyc),    32'd65537);
    chk("clamp16_done_count", 32'(done_cnt),    32'd1);
    chk("clamp16_next_count", 32'(next_cnt),    32'd1);
    chk("clamp16_slots",      32'(ifc.slots_o), 32'h0000FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rand_backoff.md
# rand_backoff

Randomized backoff timer that consumes the 16-bit pseudo-random stream of the `lfsr16` generator. On a start request it draws one random value, masks it to a binary-exponential window selected by the attempt count, then counts that many slots before pulsing `done_o`. It sits between the LFSR and any retry/arbitration controller that needs collision-style random delays. It drives the LFSR's advance input so each draw consumes exactly one fresh value.

## Interface

Parameters:
- `MAX_EXP`, default 10, upper clamp on the window exponent; legal 0..16.
- `SLOT_CYCLES`, default 1, clock cycles per backoff slot; legal ≥1.

Ports:
- `clk_i`: input, 1 bit. Clock; all state changes on its rising edge.
- `rst_i`: input, 1 bit. Reset, asynchronous and active-high.
- `start_i`: input, 1 bit. Backoff request; accepted only in IDLE.
- `attempt_i`: input, 5 bits. Attempt count k, sampled with an accepted `start_i`.
- `abort_i`: input, 1 bit. Cancels a running backoff.
- `rand_i`: input, 16 bits. Random value, connected to the LFSR output.
- `next_o`: output, 1 bit. Advance strobe, connected to the LFSR next input.
- `busy_o`: output, 1 bit. High whenever the state is not IDLE.
- `done_o`: output, 1 bit. One-cycle pulse when the backoff completes.
- `slots_o`: output, 16 bits. Masked slot count m from the most recent draw.

## Operation

- The state machine has four states: IDLE, DRAW, WAIT and DONE.
- **IDLE**
  - `start_i`=1 and `abort_i`=0: latch e = min(`attempt_i`, MAX_EXP), then go to DRAW.
  - Otherwise stay in IDLE.
- **DRAW** (exactly one cycle)
  - `next_o`=1.
  - Compute m = `rand_i` & ((1<<e)-1). Compute the mask in 17 bits so that e=16 gives 16'hFFFF and e=0 gives 0.
  - Register m into `slots_o` and into the slot counter s.
  - m==0: go to DONE.
  - Otherwise load the prescaler p = SLOT_CYCLES-1 and go to WAIT.
- **WAIT**
  - p≠0: decrement p.
  - p==0 and s==1: go to DONE.
  - p==0 and s>1: decrement s and reload p = SLOT_CYCLES-1.
  - WAIT therefore lasts exactly m×SLOT_CYCLES cycles.
- **DONE**: `done_o`=1 for one cycle, then go to IDLE.
- **Abort**: `abort_i`=1 in DRAW or WAIT goes to IDLE on the next edge, with no `done_o`.
  - An abort in DRAW still pulses `next_o` in that cycle and still updates `slots_o`.
  - `abort_i` has no effect in IDLE or DONE.
- **Ignored starts**: `start_i` outside IDLE is ignored and is not queued. This includes the DONE cycle.
- **Simultaneous events**: `start_i` and `abort_i` together in IDLE means no start; abort has priority.
- **Counter widths**
  - s is 16 bits.
  - p is max(1, $clog2(SLOT_CYCLES)) bits.
  - Neither counter wraps; both are only decremented from nonzero values.
- **LFSR usage**: `next_o` is asserted only in DRAW, so exactly one LFSR advance happens per accepted start.

## Timing

- **Reset**: asserting `rst_i` immediately forces the IDLE state. While reset is asserted:
  - `next_o`=0, `busy_o`=0, `done_o`=0.
  - `slots_o`=0, s=0, p=0, e=0.
- **Reset mid-operation**: takes effect without waiting for a clock edge. No `done_o` is produced and no `next_o` is issued afterwards.
- **Latency**: for a start accepted at edge t:
  - DRAW occupies cycle t+1.
  - WAIT occupies cycles t+2 .. t+1+m×SLOT_CYCLES.
  - `done_o` is high in cycle t+2+m×SLOT_CYCLES.
  - `busy_o` is high from t+1 through the DONE cycle inclusive.
- **Back-to-back operation**: the earliest next accepted start is the cycle after DONE.
- **Output sourcing**: `done_o`, `busy_o` and `next_o` are decoded from registered state with no input-to-output combinational path. `slots_o` is a register.
- **Input sampling**: `rand_i` is sampled only in DRAW. The LFSR registers its advance at the end of that cycle, so the next draw sees a new value.

## Test plan

- **Basic draw**: SLOT_CYCLES=4, MAX_EXP=10, `rand_i`=16'hACE1, start with `attempt_i`=3 at t.
  - Expect `next_o` high only at t+1.
  - Expect `slots_o`=1.
  - Expect `done_o` only at t+6, and `busy_o` high over t+1..t+6.
- **Zero window**: `attempt_i`=0, any `rand_i`.
  - Expect `slots_o`=0 and `done_o` at t+2.
- **Clamp**: `attempt_i`=20, `rand_i`=16'hFFFF, SLOT_CYCLES=1.
  - Expect e=10 and `slots_o`=1023.
  - Expect `done_o` at t+1025.
  - Repeat with MAX_EXP=16: expect `slots_o`=16'hFFFF.
- **Abort**: abort in WAIT of the basic draw at t+3.
  - Expect IDLE at t+4 and no `done_o`.
  - A new start at t+4 is accepted, producing a second `next_o` pulse.
- **Async reset**: assert `rst_i` mid-WAIT between clock edges.
  - Expect `busy_o`, `slots_o` and `done_o` to be 0 immediately.
  - After deassertion, a start behaves as in the basic draw.
- **Ignored starts**: hold `start_i`=1 continuously through an entire backoff, and also assert `start_i`+`abort_i` together in IDLE.
  - The continuous start produces exactly one `next_o` per backoff; a new backoff is accepted only in IDLE, the cycle after DONE.
  - The combined `start_i`+`abort_i` in IDLE starts nothing.
